and_reduce_arbiter: RTL and testbench

Shared, chunk-serial AND-reduction engine for the digital-supply gate library. Several requesters each present an INPUT_WIDTH-bit word. A round-robin arbiter grants one requester at a time, and the granted word is reduced CHUNK_WIDTH bits per cycle into a 1-bit accumulator. The block replaces per-requester wide `_and` chains wherever area matters more than latency.

---
 rtl/and_sched_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/and_reduce_arbiter.sv | 177 +++++++++++++++++
 tb/tb_and_reduce_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/and_sched_pkg.sv
// ----------------------------------------------------------------------------
// and_sched_pkg
//
// Shared definitions for the chunk-serial AND-reduction arbiter:
//   - state_e        : controller state encoding (IDLE/EVAL/DONE)
//   - SUPPLY_OK      : the only DigitSupply value that lets the engine work
//   - num_chunks()   : number of CHUNK_WIDTH slices in an INPUT_WIDTH word
//   - clog2_min1()   : index/ID width helper that never returns 0
//
// No ports; imported by rr_arbiter and and_reduce_arbiter.
// ----------------------------------------------------------------------------
package and_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit 1 is the high rail and bit 0 the low rail; anything else is a
    // collapsed or reversed supply and the engine must not make progress.
    localparam logic [1:0] SUPPLY_OK = 2'b10;

    function automatic int num_chunks(input int input_width, input int chunk_width);
        return input_width / chunk_width;
    endfunction

    // A single-entry index still needs one bit to exist as a register.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//
// Purely combinational round-robin picker. Grants the first asserted request
// at or after ptr, scanning upward and wrapping. The pointer register itself
// lives in the parent so it can be updated only when a grant is taken.
//
// Ports:
//   req   [NUM_REQ-1:0] : request vector
//   ptr   [PTR_W-1:0]   : index with highest priority this cycle
//   grant [NUM_REQ-1:0] : one-hot grant (all zero when req is zero)
// ----------------------------------------------------------------------------
module rr_arbiter
    import and_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int PTR_W  = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found;

    // Walk priority offsets k = 0..NUM_REQ-1 from ptr; the inner loop keeps
    // every bit-select index a constant so no variable index is needed.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] && (((int'(ptr) + k) % NUM_REQ) == j)) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/and_reduce_arbiter.sv
// ----------------------------------------------------------------------------
// and_reduce_arbiter
//
// Shared AND-reduction engine. A round-robin arbiter picks one requester, its
// word is captured, then reduced CHUNK_WIDTH bits per cycle into a 1-bit
// accumulator. The result is presented with a valid/ready handshake.
//
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   DigitSupply  : supply rails, engine only advances when equal to 2'b10
//   req_valid    : per-requester request
//   req_data     : packed request words, requester i at [i*INPUT_WIDTH +: INPUT_WIDTH]
//   req_ready    : one-hot grant, word accepted on the edge where it is high
//   rsp_valid    : result available (held until rsp_ready)
//   rsp_data     : AND of all bits of the granted word
//   rsp_id       : index of the requester being answered
//   rsp_ready    : consumer accepts the result
//   busy         : high whenever the controller is not IDLE
//
// Build option:
//   AND_EARLY_EXIT_EN : when defined, EVAL ends as soon as the accumulator
//                       drops to 0 instead of walking every chunk. rsp_data
//                       is the same either way; only latency changes.
// ----------------------------------------------------------------------------
module and_reduce_arbiter
    import and_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int INPUT_WIDTH = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [1:0]                     DigitSupply,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           rsp_valid,
    output logic                           rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
    input  logic                           rsp_ready,
    output logic                           busy
);

    localparam int NUM_CHUNKS = num_chunks(INPUT_WIDTH, CHUNK_WIDTH);
    localparam int IDX_W      = clog2_min1(NUM_CHUNKS);
    localparam int ID_W       = $clog2(NUM_REQ);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

    state_e                 state_q, state_d;
    logic [INPUT_WIDTH-1:0] data_q,  data_d;
    logic [ID_W-1:0]        id_q,    id_d;
    logic                   acc_q,   acc_d;
    logic [IDX_W-1:0]       idx_q,   idx_d;
    logic [ID_W-1:0]        ptr_q,   ptr_d;

    logic                   supply_ok;
    logic [NUM_REQ-1:0]     arb_req;
    logic [NUM_REQ-1:0]     grant;
    logic [ID_W-1:0]        win_id;
    logic [INPUT_WIDTH-1:0] win_data;
    logic                   chunk_all_ones;
    logic                   acc_next;

    assign supply_ok = (DigitSupply == SUPPLY_OK);

    // Requests are only visible to the arbiter in IDLE with a good supply.
    // rst_n also gates them so req_ready reads 0 while reset is held.
    assign arb_req = (rst_n && supply_ok && (state_q == IDLE)) ? req_valid : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req   (arb_req),
        .ptr   (ptr_q),
        .grant (grant)
    );

    // Turn the one-hot grant into the winner index and its word.
    always_comb begin
        win_id   = '0;
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                win_id   = ID_W'(k);
                win_data = req_data[k*INPUT_WIDTH +: INPUT_WIDTH];
            end
        end
    end

    // Reduce the chunk currently selected by idx_q.
    always_comb begin
        chunk_all_ones = 1'b1;
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            if (idx_q == IDX_W'(c)) begin
                chunk_all_ones = &data_q[c*CHUNK_WIDTH +: CHUNK_WIDTH];
            end
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        id_d     = id_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        acc_next = acc_q & chunk_all_ones;

        case (state_q)
            IDLE: begin
                if (grant != '0) begin
                    data_d  = win_data;
                    id_d    = win_id;
                    acc_d   = 1'b1;
                    idx_d   = '0;
                    ptr_d   = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                // A bad supply freezes both the accumulator and the index.
                if (supply_ok) begin
                    acc_d = acc_next;
                    // The index stops at the last chunk rather than wrapping.
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
`ifdef AND_EARLY_EXIT_EN
                    if (!acc_next) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            id_q    <= '0;
            acc_q   <= 1'b1;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign req_ready = grant;
    assign rsp_valid = (state_q == DONE);
    // The accumulator idles at 1, so mask it to keep rsp_data low outside DONE.
    assign rsp_data  = rsp_valid & acc_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_and_reduce_arbiter.sv
// ----------------------------------------------------------------------------
// tb_and_reduce_arbiter
//
// Self-checking bench for and_reduce_arbiter (default parameters). Grants are
// pushed to a scoreboard queue with the expected result and latency; a monitor
// pops and compares when the DUT presents its response. Expected latency
// follows the AND_EARLY_EXIT_EN build option.
// ----------------------------------------------------------------------------
module tb_and_reduce_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int INPUT_WIDTH = 32;
    localparam int CHUNK_WIDTH = 8;
    localparam int NUM_CHUNKS  = INPUT_WIDTH / CHUNK_WIDTH;

    logic                           clk;
    logic                           rst_n;
    logic [1:0]                     DigitSupply;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*INPUT_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           rsp_valid;
    logic                           rsp_data;
    logic [1:0]                     rsp_id;
    logic                           rsp_ready;
    logic                           busy;

    typedef struct {
        int          id;
        logic [31:0] word;
        logic        exp_data;
    } vec_t;

    typedef struct {
        int   id;
        logic exp_data;
        int   lat;
        int   gcyc;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[8];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   seen_first = 0;

    and_reduce_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .INPUT_WIDTH (INPUT_WIDTH),
        .CHUNK_WIDTH (CHUNK_WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .DigitSupply (DigitSupply),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id),
        .rsp_ready   (rsp_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected grant-to-rsp_valid latency for a word, without stalls.
    function automatic int ref_latency(input logic [31:0] w);
`ifdef AND_EARLY_EXIT_EN
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            if (w[c*CHUNK_WIDTH +: CHUNK_WIDTH] != 8'hFF) return c + 2;
        end
`endif
        return NUM_CHUNKS + 1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Response monitor: latency at first rsp_valid, data/id at acceptance.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen_first = 0;
        end else begin
            if (rsp_valid && !seen_first) begin
                seen_first = 1;
                if (sb.size() == 0) begin
                    checkOutput("spurious_rsp_valid", 32'(rsp_valid), 32'd0);
                end else begin
                    checkOutput("rsp_latency", 32'(cyc - sb[0].gcyc), 32'(sb[0].lat));
                end
            end
            if (rsp_valid && rsp_ready) begin
                seen_first = 0;
                if (sb.size() != 0) begin
                    sb_t e;
                    e = sb.pop_front();
                    checkOutput("rsp_data", 32'(rsp_data), 32'(e.exp_data));
                    checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
                end
            end
        end
    end

    // Wait (bounded) for a grant, check it targets id, push the expectation.
    task automatic waitGrant(input int id, input logic [31:0] word, input logic exp_data,
                             input int stall, output int gcyc);
        bit got;
        logic [NUM_REQ-1:0] g;
        got  = 0;
        g    = '0;
        gcyc = -1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                got  = 1;
                g    = req_ready;
                gcyc = cyc;
            end
        end
        checkOutput("grant", 32'(g), 32'(1 << id));
        if (got) sb.push_back('{id, exp_data, ref_latency(word) + stall, gcyc});
    endtask

    // Raise one request, wait for its grant, then drop it and scramble the word.
    task automatic applyStimulus(input int id, input logic [31:0] word, input logic exp_data,
                                 input int stall);
        int g;
        @(posedge clk); #1;
        req_valid[id] = 1'b1;
        req_data[id*INPUT_WIDTH +: INPUT_WIDTH] = word;
        waitGrant(id, word, exp_data, stall, g);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        req_data[id*INPUT_WIDTH +: INPUT_WIDTH] = ~word;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
        checkOutput("drain_pending", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rr_words[4];
        int rr_order[5];
        int g, prev_g;
        bit got;

        vecs[0] = '{0, 32'hFFFF_FFFF, 1'b1};
        vecs[1] = '{2, 32'hFFFF_FF7F, 1'b0};
        vecs[2] = '{1, 32'hFFFF_00FF, 1'b0};
        vecs[3] = '{3, 32'h7FFF_FFFF, 1'b0};
        vecs[4] = '{1, 32'h0000_0000, 1'b0};
        vecs[5] = '{3, 32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{0, 32'hFEFF_FFFF, 1'b0};
        vecs[7] = '{2, 32'hFFFE_FFFF, 1'b0};

        rr_words[0] = 32'hFFFF_FFFF;
        rr_words[1] = 32'hFFFF_7FFF;
        rr_words[2] = 32'hFFFF_FFFF;
        rr_words[3] = 32'hFFFF_FFFF;
        rr_order[0] = 0; rr_order[1] = 1; rr_order[2] = 2; rr_order[3] = 3; rr_order[4] = 0;

        rst_n       = 1'b0;
        DigitSupply = 2'b10;
        req_valid   = '0;
        req_data    = '0;
        rsp_ready   = 1'b1;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Round robin with every requester held valid: 0,1,2,3,0.
        $display("[TB] round-robin sequence");
        @(posedge clk); #1;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*INPUT_WIDTH +: INPUT_WIDTH] = rr_words[i];
        req_valid = '1;
        prev_g = -1;
        for (int n = 0; n < 5; n++) begin
            int rid;
            rid = rr_order[n];
            waitGrant(rid, rr_words[rid], (rr_words[rid] == 32'hFFFF_FFFF), 0, g);
            if (n > 0) checkOutput("rr_grant_spacing", 32'(g - prev_g),
                                   32'(ref_latency(rr_words[rr_order[n-1]]) + 1));
            prev_g = g;
        end
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        // Table-driven single requests.
        $display("[TB] vector table");
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].id, vecs[v].word, vecs[v].exp_data, 0);
            drain();
        end

        // Supply stalls EVAL for 3 cycles.
        $display("[TB] supply stall in EVAL");
        applyStimulus(1, 32'hFF00_FFFF, 1'b0, 3);
        DigitSupply = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        DigitSupply = 2'b10;
        drain();

        // Request in IDLE with a bad supply is not granted.
        $display("[TB] supply invalid in IDLE");
        @(posedge clk); #1;
        DigitSupply = 2'b00;
        req_valid[2] = 1'b1;
        req_data[2*INPUT_WIDTH +: INPUT_WIDTH] = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("no_grant_bad_supply", 32'(req_ready), 32'd0);
            checkOutput("idle_busy_bad_supply", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
        DigitSupply = 2'b10;
        waitGrant(2, 32'hFFFF_FFFF, 1'b1, 0, g);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        drain();

        // Backpressure in DONE: outputs stable, no new grant.
        $display("[TB] backpressure in DONE");
        rsp_ready = 1'b0;
        applyStimulus(3, 32'hFFFF_FFFF, 1'b1, 0);
        req_valid[0] = 1'b1;
        req_data[0 +: INPUT_WIDTH] = 32'hFFFF_FFFF;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        checkOutput("bp_rsp_valid_rise", 32'(got), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_rsp_data", 32'(rsp_data), 32'd1);
            checkOutput("bp_rsp_id", 32'(rsp_id), 32'd3);
            checkOutput("bp_no_grant", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        waitGrant(0, 32'hFFFF_FFFF, 1'b1, 0, g);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        drain();

        // Reset during EVAL discards the word; requester 0 wins first after.
        $display("[TB] reset during EVAL");
        applyStimulus(1, 32'hFFFF_FFFF, 1'b1, 0);
        for (int i = 0; i < NUM_REQ; i++) req_data[i*INPUT_WIDTH +: INPUT_WIDTH] = 32'hFFFF_FFFF;
        req_valid = '1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checkOutput("mid_reset_busy", 32'(busy), 32'd0);
        checkOutput("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mid_reset_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("mid_reset_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitGrant(0, 32'hFFFF_FFFF, 1'b1, 0, g);
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
